// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: Diff = A - B - Bin (mod 2^WIDTH), one DIGIT-bit slice per cycle, LSB first.
// Define SUB_OVF_EN to add the signed-overflow output Ovf.
module digit_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Bin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] acc_q;
`ifdef SUB_OVF_EN
  logic             a_msb_q;
  logic             b_msb_q;
`endif

  logic [DIGIT:0]   slice;
  logic [DIGIT-1:0] slice_diff;
  logic             slice_bout;
  logic [WIDTH-1:0] acc_next;
  logic             last_slice;

  // Borrow-lookahead slice: each borrow is formed directly from G/P terms
  // rather than rippling through the previous bit's borrow.
  function automatic logic [DIGIT:0] sub_slice(input logic [DIGIT-1:0] a,
                                               input logic [DIGIT-1:0] b,
                                               input logic             bin);
    logic [DIGIT-1:0] g;
    logic [DIGIT-1:0] p;
    logic [DIGIT:0]   br;
    logic             term;
    logic             pp;
    g     = ~a & b;
    p     = ~(a ^ b);
    br[0] = bin;
    for (int i = 0; i < DIGIT; i++) begin
      term = 1'b0;
      pp   = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      br[i+1] = term | (pp & bin);
    end
    return {br[DIGIT], a ^ b ^ br[DIGIT-1:0]};
  endfunction

  always_comb begin
    slice      = sub_slice(a_q[DIGIT-1:0], b_q[DIGIT-1:0], borrow_q);
    slice_diff = slice[DIGIT-1:0];
    slice_bout = slice[DIGIT];
    // Result slices enter at the top and drift down, so after the last slice
    // the accumulator holds the full difference in natural bit order.
    acc_next   = (acc_q >> DIGIT) | (WIDTH'(slice_diff) << (WIDTH - DIGIT));
    last_slice = (idx_q == IDX_W'(NSLICE - 1));
  end

  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      Diff     <= '0;
      Bout     <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      Ovf      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            state_q  <= RUN;
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            idx_q    <= '0;
            acc_q    <= '0;
`ifdef SUB_OVF_EN
            a_msb_q  <= A[WIDTH-1];
            b_msb_q  <= B[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          borrow_q <= slice_bout;
          acc_q    <= acc_next;
          idx_q    <= idx_q + IDX_W'(1);
          // Results are published only on the DONE entry edge.
          if (last_slice) begin
            state_q <= DONE;
            Diff    <= acc_next;
            Bout    <= slice_bout;
`ifdef SUB_OVF_EN
            Ovf     <= (a_msb_q != b_msb_q) & (acc_next[WIDTH-1] != a_msb_q);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
